// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: default width, opcode encoding
// and the shifter direction encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;
    localparam int unsigned ALU_SHW   = $clog2(ALU_WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SRA = 3'b111
    } opcode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/alu_shifter.sv
// Combinational log-stage barrel shifter. Left shifts reuse the right-shift
// stages by bit-reversing the data on the way in and out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    input  logic             dir,
    input  logic             arith,
    output logic [WIDTH-1:0] result,
    output logic             shout
);

    logic                   fill;
    logic [WIDTH-1:0]       src;
    logic [WIDTH-1:0]       rev;
    logic [SHW:0][WIDTH-1:0] stg;
    logic [SHW:0]           so;

    assign fill = arith & (dir == DIR_RIGHT) & data[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign src[i] = (dir == DIR_RIGHT) ? data[i] : data[WIDTH-1-i];
        assign rev[i] = stg[SHW][WIDTH-1-i];
    end

    assign stg[0] = src;
    assign so[0]  = 1'b0;

    // Each taken stage records its last bit shifted out; the highest taken
    // stage therefore holds data[s-1] of the overall shift.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned STEP = 2 ** k;
        assign stg[k+1] = amount[k] ? {{STEP{fill}}, stg[k][WIDTH-1:STEP]} : stg[k];
        assign so[k+1]  = amount[k] ? stg[k][STEP-1] : so[k];
    end

    assign result = (dir == DIR_RIGHT) ? stg[SHW] : rev;
    assign shout  = so[SHW];

endmodule

// File: rtl/alu.sv
// Registered 16-bit arithmetic/logic/shift unit: one result word and one
// carry/shift-out flag per cycle, selected by a 3-bit opcode.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] outp,
    output logic             cout
);

    opcode_e          opc;
    logic             sub;
    logic [WIDTH-1:0] addb;
    logic [WIDTH:0]   addsum;
    logic [WIDTH-1:0] shres;
    logic             shout;
    logic             shdir;
    logic             sharith;
    logic [WIDTH-1:0] outp_d, outp_q;
    logic             cout_d, cout_q;

    assign opc = opcode_e'(op);

    // Subtract as i0 + ~i1 + 1 so the carry out is the no-borrow flag.
    assign sub    = (opc == OP_SUB);
    assign addb   = sub ? ~i1 : i1;
    assign addsum = {1'b0, i0} + {1'b0, addb} + {{WIDTH{1'b0}}, sub};

    assign shdir   = (opc == OP_SLL) ? DIR_LEFT : DIR_RIGHT;
    assign sharith = (opc == OP_SRA);

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data   (i0),
        .amount (i1[SHW-1:0]),
        .dir    (shdir),
        .arith  (sharith),
        .result (shres),
        .shout  (shout)
    );

    always_comb begin
        outp_d = '0;
        cout_d = 1'b0;
        unique case (opc)
            OP_ADD, OP_SUB: begin
                outp_d = addsum[WIDTH-1:0];
                cout_d = addsum[WIDTH];
            end
            OP_AND: outp_d = i0 & i1;
            OP_OR:  outp_d = i0 | i1;
            OP_XOR: outp_d = i0 ^ i1;
            OP_SLL, OP_SRL, OP_SRA: begin
                outp_d = shres;
                cout_d = shout;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outp_q <= '0;
            cout_q <= 1'b0;
        end else begin
            outp_q <= outp_d;
            cout_q <= cout_d;
        end
    end

    assign outp = outp_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors from the test plan followed by
// random operations checked against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [2:0]  op;
    logic [15:0] i0;
    logic [15:0] i1;
    logic [15:0] outp;
    logic        cout;

    int n_assert = 0;
    int n_fail   = 0;

    alu u_dut (
        .clk  (clk),
        .rst  (rst),
        .op   (op),
        .i0   (i0),
        .i1   (i1),
        .outp (outp),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {cout, outp} for the two directed sweeps, indexed by opcode.
    logic [16:0] sweep_a [8] = '{17'h0_5B90, 17'h1_5B6E, 17'h0_0011, 17'h0_5B7F,
                                 17'h0_5B6E, 17'h0_B6FE, 17'h1_2DBF, 17'h1_2DBF};
    logic [16:0] sweep_b [8] = '{17'h0_CB7E, 17'h0_EB80, 17'h0_4B7F, 17'h0_7FFF,
                                 17'h0_3480, 17'h1_8000, 17'h1_0000, 17'h1_0000};

    function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
        int unsigned s;
        logic [16:0] r;
        s = int'(b[3:0]);
        r = '0;
        case (o)
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: r = {(a >= b), 16'(a - b)};
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            3'd5: begin
                r[15:0] = a << s;
                r[16]   = (s == 0) ? 1'b0 : a[16-s];
            end
            3'd6: begin
                r[15:0] = a >> s;
                r[16]   = (s == 0) ? 1'b0 : a[s-1];
            end
            default: begin
                r[15:0] = 16'($signed(a) >>> s);
                r[16]   = (s == 0) ? 1'b0 : a[s-1];
            end
        endcase
        return r;
    endfunction

    task automatic step(input logic r, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b);
        rst = r;
        op  = o;
        i0  = a;
        i1  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [16:0] exp);
        n_assert++;
        assert (outp === exp[15:0]) else begin
            n_fail++;
            $error("FAIL %s outp got %h expected %h", tag, outp, exp[15:0]);
        end
        n_assert++;
        assert (cout === exp[16]) else begin
            n_fail++;
            $error("FAIL %s cout got %b expected %b", tag, cout, exp[16]);
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rr;

        rst = 1'b1;
        op  = '0;
        i0  = '0;
        i1  = '0;

        // Reset with arbitrary inputs on the ports.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 3'($urandom), 16'($urandom), 16'($urandom));
            check("reset", 17'h0_0000);
        end

        for (int o = 0; o < 8; o++) begin
            step(1'b0, 3'(o), 16'h5B7F, 16'h0011);
            check($sformatf("sweep_a op%0d", o), sweep_a[o]);
        end
        for (int o = 0; o < 8; o++) begin
            step(1'b0, 3'(o), 16'h5B7F, 16'h6FFF);
            check($sformatf("sweep_b op%0d", o), sweep_b[o]);
        end

        step(1'b0, 3'd0, 16'hFFFF, 16'h0001);
        check("add_wrap", 17'h1_0000);
        step(1'b0, 3'd1, 16'h1234, 16'h1234);
        check("sub_equal", 17'h1_0000);
        step(1'b0, 3'd7, 16'h8000, 16'h0004);
        check("sra_sign", 17'h0_F800);

        for (int o = 5; o < 8; o++) begin
            step(1'b0, 3'(o), 16'hA5A5, 16'hFFF0);
            check($sformatf("zero_shift op%0d", o), 17'h0_A5A5);
        end

        // Reset in the middle of a sweep, then resume where it left off.
        for (int o = 0; o < 3; o++) begin
            step(1'b0, 3'(o), 16'h5B7F, 16'h0011);
            check($sformatf("pre_rst op%0d", o), sweep_a[o]);
        end
        step(1'b1, 3'd3, 16'h5B7F, 16'h0011);
        check("mid_rst", 17'h0_0000);
        for (int o = 3; o < 8; o++) begin
            step(1'b0, 3'(o), 16'h5B7F, 16'h0011);
            check($sformatf("post_rst op%0d", o), sweep_a[o]);
        end

        for (int n = 0; n < 400; n++) begin
            ro = 3'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            rr = ($urandom_range(0, 31) == 0);
            step(rr, ro, ra, rb);
            check($sformatf("rand%0d op%0d %h %h", n, ro, ra, rb),
                  rr ? 17'h0_0000 : model(ro, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
